mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_rdata_router.sv | 51 +++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the CPU/graphics memory arbiter.
// Arbiter states, read-owner encoding and the default burst limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU,
        ST_GFX,
        ST_HANDOVER
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_GFX
    } owner_t;

    localparam int MAX_BURST_DEF = 8;
    localparam int CNT_W         = 8;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_arb_rdata_router.sv
// Read-data return path: remembers who issued the last read and
// steers dcache_dout / rvalid to that owner, holding across stalls.
module mem_arb_rdata_router
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic        cpu_rd,
    input  logic        gfx_rd,
    input  logic [31:0] dcache_dout,
    output logic        cpu_rvalid,
    output logic        gfx_rvalid,
    output logic [31:0] cpu_dout,
    output logic [31:0] gfx_dout
);

    owner_t      pend;
    logic [31:0] cpu_hold;
    logic [31:0] gfx_hold;

    // Owner of the read issued this cycle; frozen while the port is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= OWN_NONE;
        end else if (!mem_stall) begin
            unique case (1'b1)
                cpu_rd:  pend <= OWN_CPU;
                gfx_rd:  pend <= OWN_GFX;
                default: pend <= OWN_NONE;
            endcase
        end
    end

    assign cpu_rvalid = (pend == OWN_CPU) && !mem_stall;
    assign gfx_rvalid = (pend == OWN_GFX) && !mem_stall;
    assign cpu_dout   = cpu_rvalid ? dcache_dout : cpu_hold;
    assign gfx_dout   = gfx_rvalid ? dcache_dout : gfx_hold;

    // Keep the last delivered word on each dout between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_hold <= '0;
            gfx_hold <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold <= dcache_dout;
            if (gfx_rvalid) gfx_hold <= dcache_dout;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / graphics) arbiter for a single dcache port.
// Define MEM_ARB_RR_EN to alternate priority on IDLE ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic [3:0]  cpu_we,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_dout,
    input  logic        gfx_req,
    input  logic        gfx_re,
    input  logic        gfx_last,
    input  logic [31:0] gfx_addr,
    input  logic [31:0] gfx_din,
    input  logic [3:0]  gfx_we,
    output logic        gfx_gnt,
    output logic        gfx_rvalid,
    output logic [31:0] gfx_dout,
    output logic [31:0] dcache_addr,
    output logic [31:0] dcache_din,
    output logic [3:0]  dcache_we,
    output logic        dcache_re,
    input  logic [31:0] dcache_dout,
    input  logic        mem_stall
);

    localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cpu_win;
    logic [31:0]      addr_q;
    logic [31:0]      din_q;
`ifdef MEM_ARB_RR_EN
    logic             last_gfx;
`endif

    assign cnt_inc = (cnt == MAX_B) ? cnt : cnt + CNT_W'(1);

    // Who wins an IDLE decision when both sides are requesting.
    always_comb begin
        cpu_win = cpu_req;
`ifdef MEM_ARB_RR_EN
        if (cpu_req && gfx_req) cpu_win = last_gfx;
`endif
    end

    // Grants come from state and live requests; stall/reset mask them.
    // In CPU state an idle CPU hands the port straight to graphics.
    always_comb begin
        cpu_gnt = 1'b0;
        gfx_gnt = 1'b0;
        if (!rst && !mem_stall) begin
            unique case (state)
                ST_IDLE: begin
                    cpu_gnt = cpu_win;
                    gfx_gnt = gfx_req && !cpu_win;
                end
                ST_CPU: begin
                    cpu_gnt = cpu_req;
                    gfx_gnt = gfx_req && !cpu_req;
                end
                ST_GFX:  gfx_gnt = gfx_req && (cnt < MAX_B);
                default: ;
            endcase
        end
    end

    // Ownership state machine and graphics beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (!mem_stall) begin
            unique case (state)
                ST_IDLE: begin
                    if (cpu_gnt) begin
                        state <= ST_CPU;
                    end else if (gfx_gnt) begin
                        state <= ST_GFX;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_CPU: begin
                    if (gfx_gnt) begin
                        state <= ST_GFX;
                        cnt   <= CNT_W'(1);
                    end else if (!cpu_req) begin
                        state <= ST_IDLE;
                    end else if (gfx_req) begin
                        state <= ST_GFX;
                        cnt   <= '0;
                    end
                end
                ST_GFX: begin
                    if (gfx_gnt) cnt <= cnt_inc;
                    if (!gfx_gnt || gfx_last || cnt_inc == MAX_B)
                        state <= ST_HANDOVER;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember the last winner so IDLE ties alternate; CPU goes first.
    always_ff @(posedge clk) begin
        if (rst)          last_gfx <= 1'b1;
        else if (cpu_gnt) last_gfx <= 1'b0;
        else if (gfx_gnt) last_gfx <= 1'b1;
    end
`endif

    // Drive the shared port from the granted side, else hold addr/data.
    always_comb begin
        dcache_addr = addr_q;
        dcache_din  = din_q;
        dcache_we   = '0;
        dcache_re   = 1'b0;
        unique case (1'b1)
            cpu_gnt: begin
                dcache_addr = word_align(cpu_addr);
                dcache_din  = cpu_din;
                dcache_we   = cpu_we;
                dcache_re   = cpu_re;
            end
            gfx_gnt: begin
                dcache_addr = word_align(gfx_addr);
                dcache_din  = gfx_din;
                dcache_we   = gfx_we;
                dcache_re   = gfx_re;
            end
            default: ;
        endcase
    end

    // Last presented address/data, reused while nobody holds a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= dcache_addr;
            din_q  <= dcache_din;
        end
    end

    mem_arb_rdata_router u_router (
        .clk         (clk),
        .rst         (rst),
        .mem_stall   (mem_stall),
        .cpu_rd      (cpu_gnt && cpu_re),
        .gfx_rd      (gfx_gnt && gfx_re),
        .dcache_dout (dcache_dout),
        .cpu_rvalid  (cpu_rvalid),
        .gfx_rvalid  (gfx_rvalid),
        .cpu_dout    (cpu_dout),
        .gfx_dout    (gfx_dout)
    );

endmodule
